// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency synchronous-read memory between two ports
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int CNT_W = $clog2(RD_LAT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t           state;
    logic             last_gnt;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic             win;
    logic             gnt_any;
    logic             sel_we;
    // Round-robin winner selection and memory port steering; nothing is granted in WAIT or under reset
    always_comb begin
        win         = (p0_req_i && p1_req_i) ? ~last_gnt : p1_req_i;
        gnt_any     = reset_i && (state != WAIT) && (p0_req_i || p1_req_i);
        sel_we      = win ? p1_we_i : p0_we_i;
        p0_gnt_o    = gnt_any && !win;
        p1_gnt_o    = gnt_any && win;
        mem_en_o    = gnt_any;
        mem_we_o    = gnt_any && sel_we;
        mem_addr_o  = gnt_any ? (win ? p1_addr_i : p0_addr_i) : '0;
        mem_wdata_o = gnt_any ? (win ? p1_wdata_i : p0_wdata_i) : '0;
    end
    // Access FSM: reads park in WAIT for RD_LAT cycles, data is captured on the last one and flagged in RESP
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            p0_rvalid_o <= 1'b0;
            p1_rvalid_o <= 1'b0;
            p0_rdata_o  <= '0;
            p1_rdata_o  <= '0;
        end else begin
            p0_rvalid_o <= 1'b0;
            p1_rvalid_o <= 1'b0;
            if (gnt_any)
                last_gnt <= win;
            case (state)
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                        if (owner) begin
                            p1_rdata_o  <= mem_rdata_i;
                            p1_rvalid_o <= 1'b1;
                        end else begin
                            p0_rdata_o  <= mem_rdata_i;
                            p0_rvalid_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= (gnt_any && !sel_we) ? WAIT : IDLE;
                    if (gnt_any && !sel_we) begin
                        owner <= win;
                        cnt   <= CNT_W'(RD_LAT);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench over three arbiters with read latencies 1, 2 and 3
module tb_mem_port_arbiter;
    typedef struct {
        int          inst;
        int          cyc;
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        rst_n [3];
    logic        req [3][2];
    logic        we [3][2];
    logic [31:0] addr [3][2];
    logic [31:0] wd [3][2];
    logic        gnt [3][2];
    logic        rv [3][2];
    logic [31:0] rd [3][2];
    logic        mem_en [3];
    logic        mem_we [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    ev_t         gq [$];
    ev_t         rq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mv(logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        logic [31:0] pipe [g+1];
        always @(posedge clk) begin
            pipe[0] <= (mem_en[g] && !mem_we[g]) ? mv(mem_addr[g]) : 32'h0BAD0BAD;
            for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[g];
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g + 1)) dut (
            .clk_i(clk), .reset_i(rst_n[g]),
            .p0_req_i(req[g][0]), .p0_we_i(we[g][0]), .p0_addr_i(addr[g][0]), .p0_wdata_i(wd[g][0]),
            .p0_gnt_o(gnt[g][0]), .p0_rvalid_o(rv[g][0]), .p0_rdata_o(rd[g][0]),
            .p1_req_i(req[g][1]), .p1_we_i(we[g][1]), .p1_addr_i(addr[g][1]), .p1_wdata_i(wd[g][1]),
            .p1_gnt_o(gnt[g][1]), .p1_rvalid_o(rv[g][1]), .p1_rdata_o(rd[g][1]),
            .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
            .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g])
        );
    end

    // Monitor: every grant and every rvalid pops the next expected event and must match it exactly
    always @(negedge clk) begin
        ev_t e;
        for (int g = 0; g < 3; g++) begin
            for (int p = 0; p < 2; p++) begin
                if (gnt[g][p]) begin
                    checks++;
                    if (gq.size() == 0) begin
                        errors++;
                        $display("FAIL gnt: unexpected grant inst%0d port%0d cycle %0d", g, p, cyc);
                    end else begin
                        e = gq.pop_front();
                        if (e.inst != g || e.cyc != cyc || e.port != p || mem_en[g] !== 1'b1 ||
                            mem_we[g] !== e.we || mem_addr[g] !== e.addr || mem_wdata[g] !== e.data) begin
                            errors++;
                            $display("FAIL gnt: got inst%0d cyc%0d port%0d en%0b we%0b addr %h wdata %h, expected inst%0d cyc%0d port%0d en1 we%0b addr %h wdata %h",
                                     g, cyc, p, mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g],
                                     e.inst, e.cyc, e.port, e.we, e.addr, e.data);
                        end
                    end
                end
                if (rv[g][p]) begin
                    checks++;
                    if (rq.size() == 0) begin
                        errors++;
                        $display("FAIL rvalid: unexpected rvalid inst%0d port%0d cycle %0d", g, p, cyc);
                    end else begin
                        e = rq.pop_front();
                        if (e.inst != g || e.cyc != cyc || e.port != p || rd[g][p] !== e.data) begin
                            errors++;
                            $display("FAIL rvalid: got inst%0d cyc%0d port%0d data %h, expected inst%0d cyc%0d port%0d data %h",
                                     g, cyc, p, rd[g][p], e.inst, e.cyc, e.port, e.data);
                        end
                    end
                end
            end
            checks++;
            if (mem_en[g] !== (gnt[g][0] | gnt[g][1]) || (gnt[g][0] && gnt[g][1])) begin
                errors++;
                $display("FAIL strobe inst%0d cycle %0d: en %b gnt %b%b, required en equal to single grant",
                         g, cyc, mem_en[g], gnt[g][1], gnt[g][0]);
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int g, int p, logic r, logic w, logic [31:0] a, logic [31:0] d);
        req[g][p] = r;
        we[g][p] = w;
        addr[g][p] = a;
        wd[g][p] = d;
    endtask

    task automatic exp_gnt(int g, int c, int p, logic w, logic [31:0] a, logic [31:0] d);
        ev_t e;
        e = '{g, c, p, w, a, d};
        gq.push_back(e);
    endtask

    task automatic exp_rv(int g, int c, int p, logic [31:0] d);
        ev_t e;
        e = '{g, c, p, 1'b0, 32'h0, d};
        rq.push_back(e);
    endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_quiet(int g, string n);
        chk({n, " gnt0"}, {31'b0, gnt[g][0]}, 32'h0);
        chk({n, " gnt1"}, {31'b0, gnt[g][1]}, 32'h0);
        chk({n, " rvalid0"}, {31'b0, rv[g][0]}, 32'h0);
        chk({n, " rvalid1"}, {31'b0, rv[g][1]}, 32'h0);
        chk({n, " rdata0"}, rd[g][0], 32'h0);
        chk({n, " rdata1"}, rd[g][1], 32'h0);
        chk({n, " mem_en"}, {31'b0, mem_en[g]}, 32'h0);
        chk({n, " mem_we"}, {31'b0, mem_we[g]}, 32'h0);
        chk({n, " mem_addr"}, mem_addr[g], 32'h0);
        chk({n, " mem_wdata"}, mem_wdata[g], 32'h0);
    endtask

    initial begin
        int c;
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0;
            put(g, 0, 0, 0, 0, 0);
            put(g, 1, 0, 0, 0, 0);
        end
        go();
        put(0, 0, 1, 1, 32'h44, 32'h1234);
        #1;
        for (int g = 0; g < 3; g++) chk_quiet(g, $sformatf("reset inst%0d", g));
        put(0, 0, 0, 0, 0, 0);
        go();
        for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
        repeat (2) go();

        // both ports read out of reset: p0 wins the tie, p1 is granted in p0's RESP cycle
        c = cyc;
        put(1, 0, 1, 0, 32'h20, 0);
        put(1, 1, 1, 0, 32'h24, 0);
        exp_gnt(1, c, 0, 0, 32'h20, 0);
        exp_rv(1, c + 3, 0, mv(32'h20));
        exp_gnt(1, c + 3, 1, 0, 32'h24, 0);
        exp_rv(1, c + 6, 1, mv(32'h24));
        go();
        put(1, 0, 0, 0, 0, 0);
        repeat (3) go();
        put(1, 1, 0, 0, 0, 0);
        repeat (5) go();

        // both ports hold writes: grants alternate p0,p1 every cycle
        for (int k = 0; k < 6; k++) begin
            put(1, 0, 1, 1, 32'h100 + 4 * k, 32'hA0000000 + k);
            put(1, 1, 1, 1, 32'h200 + 4 * k, 32'hB0000000 + k);
            if (k % 2 == 0) exp_gnt(1, cyc, 0, 1, 32'h100 + 4 * k, 32'hA0000000 + k);
            else exp_gnt(1, cyc, 1, 1, 32'h200 + 4 * k, 32'hB0000000 + k);
            go();
        end
        put(1, 0, 0, 0, 0, 0);
        put(1, 1, 0, 0, 0, 0);
        repeat (2) go();

        // single read, latency 2
        c = cyc;
        put(1, 0, 1, 0, 32'h10, 0);
        exp_gnt(1, c, 0, 0, 32'h10, 0);
        exp_rv(1, c + 3, 0, 32'hDEADBEEF);
        go();
        put(1, 0, 0, 0, 0, 0);
        repeat (4) go();

        // p1 write arrives during p0's WAIT and is granted in p0's RESP cycle
        c = cyc;
        put(1, 0, 1, 0, 32'h30, 0);
        exp_gnt(1, c, 0, 0, 32'h30, 0);
        exp_rv(1, c + 3, 0, mv(32'h30));
        exp_gnt(1, c + 3, 1, 1, 32'h34, 32'h5555AAAA);
        go();
        put(1, 0, 0, 0, 0, 0);
        put(1, 1, 1, 1, 32'h34, 32'h5555AAAA);
        repeat (3) go();
        put(1, 1, 0, 0, 0, 0);
        repeat (3) go();

        // latency 3: reset during p1's WAIT abandons the read, then p0 is served from IDLE
        c = cyc;
        put(2, 1, 1, 0, 32'h40, 0);
        exp_gnt(2, c, 1, 0, 32'h40, 0);
        go();
        put(2, 1, 0, 0, 0, 0);
        rst_n[2] = 1'b0;
        put(2, 0, 1, 0, 32'h44, 0);
        #1;
        chk_quiet(2, "mid-read reset");
        exp_gnt(2, c + 2, 0, 0, 32'h44, 0);
        exp_rv(2, c + 6, 0, mv(32'h44));
        go();
        rst_n[2] = 1'b1;
        go();
        put(2, 0, 0, 0, 0, 0);
        repeat (6) go();
        chk("abandoned p1 rdata", rd[2][1], 32'h0);

        // latency 1: four back-to-back reads with req held, address changed while waiting
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            put(0, 0, 1, 0, 32'h50 + 4 * k, 0);
            exp_gnt(0, c + 2 * k, 0, 0, 32'h50 + 4 * k, 0);
            exp_rv(0, c + 2 * k + 2, 0, mv(32'h50 + 4 * k));
            go();
            go();
        end
        put(0, 0, 0, 0, 0, 0);
        repeat (3) go();
        chk("rdata hold", rd[0][0], mv(32'h5C));

        for (int i = 0; i < 20 && (gq.size() != 0 || rq.size() != 0); i++) go();
        checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d grants and %0d rvalids outstanding, expected 0 and 0", gq.size(), rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
